piece_dropper: RTL and testbench
================================

Name: piece_dropper

Overview:
- Owns the 84-bit Connect-Four board register (6 rows x 7 cols x 2 bits per cell).
- Accepts a drop request for one column and one player, and animates the piece falling one row at a time from the top row.
- Writes the token into the lowest empty cell, then reports done, or reports failure.
- Drives board_state to the rest of the game logic (win detection, column-space checking, VGA renderer).

Parameters:
- ROWS, 6, number of board rows; row 0 is the top, row ROWS-1 is the bottom.
- COLS, 7, number of board columns.
- FALL_DIV, 1, clock cycles the falling piece dwells on each row. Use 1 for simulation; the board build uses the display-rate value (e.g. 5_000_000).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- drop_req  in  1  request to drop a piece; sampled only in IDLE
- column  in  3  target column, 0..COLS-1; sampled with drop_req
- player  in  2  token code, 2'b01 (P1) or 2'b10 (P2); sampled with drop_req
- clear_board  in  1  synchronous board clear
- board_state  out  84  cell (r,c) at bits [(r*COLS+c)*2 +: 2]; 00 = EMPTY
- busy  out  1  high whenever the FSM is not in IDLE
- fall_valid  out  1  a falling piece is in flight
- fall_row  out  3  row currently occupied by the falling piece
- fall_col  out  3  column of the falling piece
- drop_done  out  1  one-cycle pulse; the piece has landed
- drop_fail  out  1  one-cycle pulse; the request was rejected
- placed_row  out  3  landing row; valid while drop_done is high and held until the next request

Behaviour:
- Reset (asynchronous, any state):
  - board_state = all zero; FSM = IDLE.
  - busy, fall_valid, drop_done, drop_fail = 0.
  - fall_row, fall_col, placed_row = 0; fall counter = 0.
- All outputs are registered.
- States: IDLE, CHECK, FALL, LAND, FAIL.
- IDLE:
  - On drop_req = 1, latch column and player and go to CHECK.
  - If drop_req is not asserted, stay in IDLE.
- CHECK (one cycle):
  - Go to FAIL if column >= COLS, or player is not 01/10, or cell(0,col) != EMPTY (column full).
  - Otherwise go to FALL with fall_row = 0, fall_col = col, fall_valid = 1, counter = 0.
- FALL:
  - The counter increments each cycle.
  - When the counter reaches FALL_DIV-1, reset the counter, then:
    - if fall_row == ROWS-1, or cell(fall_row+1,col) != EMPTY, go to LAND;
    - else increment fall_row.
- LAND (one cycle):
  - Write cell(fall_row,col) <= player.
  - placed_row <= fall_row; drop_done = 1; fall_valid = 0.
  - Go to IDLE.
- FAIL (one cycle): drop_fail = 1; return to IDLE.
- Pulse timing: drop_done is high in exactly the cycle in which board_state first shows the new token. drop_fail is high for exactly one cycle.
- Latency, counted from the clock edge that samples drop_req:
  - board update and drop_done appear 2 + (r+1)*FALL_DIV cycles later, where r is the landing row;
  - drop_fail appears 2 cycles later.
- busy rises 1 cycle after sampling and falls in the cycle after drop_done or drop_fail.
- drop_req while busy is ignored. It is not queued, and no pulse is produced.
- clear_board:
  - Highest priority; wins over drop_req in the same cycle.
  - Next edge: board_state = 0, FSM = IDLE, fall_valid = 0, counter = 0.
  - An in-flight drop is aborted with neither drop_done nor drop_fail.
- Only the target cell changes on a drop; all other 82 bits are unchanged.
- The board is never written outside the LAND state, never writes a cell that is non-EMPTY, and never leaves the board region (no index wrap-around).
- Rows only increase during FALL. fall_row never exceeds ROWS-1.

Decomposition:
- Package connect4_pkg holds:
  - ROWS, COLS, CELL_W = 2;
  - EMPTY = 2'b00, PLAYER1 = 2'b01, PLAYER2 = 2'b10;
  - the state enum type;
  - a function cell_idx(row,col) returning (row*COLS+col)*2.
- One natural sub-module, fall_timer: a FALL_DIV counter with enable and clear, and a one-cycle tick output. The FSM and board register stay in piece_dropper.

Test Plan:
- Reset, then drop col 3 P1 with FALL_DIV=1 -> fall_row steps 0..5; drop_done 8 cycles after the sampling edge; placed_row = 5; board bits [76:77] = 01, all else 0.
- Pre-fill col 0 rows 5..2, then drop P2 into col 0 -> lands at row 1; drop_done after 4 cycles; bits [14:15] = 10.
- Column full (row 0 occupied) -> drop_fail 2 cycles after sampling; board unchanged; no drop_done. Separately, column = 7 -> drop_fail; player = 2'b11 -> drop_fail.
- drop_req pulsed again while busy with a different column -> ignored; exactly one drop_done; only the first column written.
- clear_board asserted mid-FALL on a non-empty board -> next edge board = 0, busy = 0, no done/fail pulse. Then clear_board and drop_req asserted in the same cycle -> clear wins and the request is not accepted.
- rst asserted asynchronously mid-FALL with FALL_DIV=4 -> outputs drop to reset values immediately; after release, a new drop into the same column lands at row 5.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-Four constants, FSM state type and board addressing helper.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CELL_W  = 2;
  localparam int BOARD_W = ROWS * COLS * CELL_W;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] PLAYER1 = 2'b01;
  localparam logic [1:0] PLAYER2 = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_FALL  = 3'd2,
    ST_LAND  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Bit offset of cell (row,col) inside the flat board vector.
  function automatic logic [6:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return 7'((int'(row) * COLS + int'(col)) * CELL_W);
  endfunction

endpackage

// File: rtl/piece_dropper_fall_timer.sv
// Dwell timer for the falling piece: counts FALL_DIV cycles per row and
// raises a one-cycle tick on the last cycle of each dwell period.
module fall_timer #(
  parameter int FALL_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FALL_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST_CNT);

  // Count while enabled, wrap on each tick, and restart from zero on clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of block ordering.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piece_dropper.sv
// Connect-Four board owner: accepts a column drop, animates the piece one
// row at a time from the top, writes it into the lowest empty cell and
// pulses done, or pulses fail for an illegal request.
module piece_dropper
  import connect4_pkg::*;
#(
  parameter int FALL_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               drop_req,
  input  logic [2:0]         column,
  input  logic [1:0]         player,
  input  logic               clear_board,
  output logic [BOARD_W-1:0] board_state,
  output logic               busy,
  output logic               fall_valid,
  output logic [2:0]         fall_row,
  output logic [2:0]         fall_col,
  output logic               drop_done,
  output logic               drop_fail,
  output logic [2:0]         placed_row
);

  state_t             r_state;
  logic [BOARD_W-1:0] r_board;
  logic [2:0]         r_col;
  logic [1:0]         r_player;
  logic               r_busy;
  logic               r_fall_valid;
  logic [2:0]         r_fall_row;
  logic               r_drop_done;
  logic               r_drop_fail;
  logic [2:0]         r_placed_row;

  logic       w_tick;
  logic       w_timer_en;
  logic       w_timer_clr;
  logic       w_col_bad;
  logic       w_player_bad;
  logic       w_top_full;
  logic       w_bottom;
  logic       w_below_full;
  logic [2:0] w_below_row;
  logic [6:0] w_top_idx;
  logic [6:0] w_below_idx;
  logic [6:0] w_cur_idx;

  // Request legality, evaluated on the latched column/player in CHECK.
  assign w_col_bad    = (r_col > LAST_COL);
  assign w_player_bad = (r_player != PLAYER1) && (r_player != PLAYER2);
  assign w_top_idx    = cell_idx(3'd0, r_col);
  assign w_top_full   = (r_board[w_top_idx +: CELL_W] != EMPTY);

  // Landing test; the row below is only addressed when it exists, so the
  // board read never leaves the board region.
  assign w_bottom     = (r_fall_row == LAST_ROW);
  assign w_below_row  = w_bottom ? r_fall_row : r_fall_row + 3'd1;
  assign w_below_idx  = cell_idx(w_below_row, r_col);
  assign w_below_full = !w_bottom && (r_board[w_below_idx +: CELL_W] != EMPTY);
  assign w_cur_idx    = cell_idx(r_fall_row, r_col);

  assign w_timer_en  = (r_state == ST_FALL);
  assign w_timer_clr = clear_board || (r_state != ST_FALL);

  fall_timer #(
    .FALL_DIV (FALL_DIV)
  ) u_fall_timer (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_timer_en),
    .i_clr  (w_timer_clr),
    .o_tick (w_tick)
  );

  // Drop FSM plus board register; clear_board overrides everything but reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_board      <= '0;
      r_col        <= '0;
      r_player     <= '0;
      r_busy       <= 1'b0;
      r_fall_valid <= 1'b0;
      r_fall_row   <= '0;
      r_drop_done  <= 1'b0;
      r_drop_fail  <= 1'b0;
      r_placed_row <= '0;
    end else if (clear_board) begin
      r_state      <= ST_IDLE;
      r_board      <= '0;
      r_busy       <= 1'b0;
      r_fall_valid <= 1'b0;
      r_drop_done  <= 1'b0;
      r_drop_fail  <= 1'b0;
    end else begin
      // busy trails the state by one cycle: it rises the cycle after a
      // request is sampled and falls the cycle after the done/fail pulse.
      r_busy      <= (r_state != ST_IDLE);
      r_drop_done <= 1'b0;
      r_drop_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (drop_req && !r_busy) begin
            r_col    <= column;
            r_player <= player;
            r_state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_col_bad || w_player_bad || w_top_full) begin
            r_state <= ST_FAIL;
          end else begin
            r_fall_row   <= '0;
            r_fall_valid <= 1'b1;
            r_state      <= ST_FALL;
          end
        end
        ST_FALL: begin
          if (w_tick) begin
            if (w_bottom || w_below_full) begin
              r_state <= ST_LAND;
            end else begin
              r_fall_row <= r_fall_row + 3'd1;
            end
          end
        end
        ST_LAND: begin
          r_board[w_cur_idx +: CELL_W] <= r_player;
          r_placed_row                 <= r_fall_row;
          r_drop_done                  <= 1'b1;
          r_fall_valid                 <= 1'b0;
          r_state                      <= ST_IDLE;
        end
        ST_FAIL: begin
          r_drop_fail <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign board_state = r_board;
  assign busy        = r_busy;
  assign fall_valid  = r_fall_valid;
  assign fall_row    = r_fall_row;
  assign fall_col    = r_col;
  assign drop_done   = r_drop_done;
  assign drop_fail   = r_drop_fail;
  assign placed_row  = r_placed_row;

endmodule

// File: tb/tb_piece_dropper.sv
// Scoreboard bench for piece_dropper: a board-array reference model predicts
// each drop's outcome, latency and resulting board; a monitor compares every
// done/fail pulse against the queued prediction.
module tb_piece_dropper;

  typedef struct {
    bit          fail;
    int          row;
    logic [83:0] board;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drop_req = 1'b0;
  logic [2:0]  column = '0;
  logic [1:0]  player = '0;
  logic        clear_board = 1'b0;
  logic [83:0] board_state;
  logic        busy, fall_valid, drop_done, drop_fail;
  logic [2:0]  fall_row, fall_col, placed_row;

  logic        rst4 = 1'b1;
  logic        drop_req4 = 1'b0;
  logic [2:0]  column4 = '0;
  logic [1:0]  player4 = '0;
  logic        clear4 = 1'b0;
  logic [83:0] board_state4;
  logic        busy4, fall_valid4, drop_done4, drop_fail4;
  logic [2:0]  fall_row4, fall_col4, placed_row4;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        sb[$];
  logic [1:0]  mdl[6][7];

  piece_dropper #(.FALL_DIV(1)) u_dut (
    .clk(clk), .rst(rst), .drop_req(drop_req), .column(column), .player(player),
    .clear_board(clear_board), .board_state(board_state), .busy(busy),
    .fall_valid(fall_valid), .fall_row(fall_row), .fall_col(fall_col),
    .drop_done(drop_done), .drop_fail(drop_fail), .placed_row(placed_row)
  );

  piece_dropper #(.FALL_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst4), .drop_req(drop_req4), .column(column4), .player(player4),
    .clear_board(clear4), .board_state(board_state4), .busy(busy4),
    .fall_valid(fall_valid4), .fall_row(fall_row4), .fall_col(fall_col4),
    .drop_done(drop_done4), .drop_fail(drop_fail4), .placed_row(placed_row4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [83:0] act, input logic [83:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [83:0] pack_model();
    logic [83:0] b = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        b[(r*7+c)*2 +: 2] = mdl[r][c];
    return b;
  endfunction

  function automatic void clear_model();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        mdl[r][c] = 2'b00;
  endfunction

  // Drive one request for a single cycle and queue the predicted outcome.
  task automatic issue(input int col, input int ply);
    exp_t e;
    int   r;
    @(negedge clk);
    drop_req = 1'b1;
    column   = 3'(col);
    player   = 2'(ply);
    if (col > 6 || !(ply == 1 || ply == 2) || mdl[0][col] != 2'b00) begin
      e.fail = 1'b1;
      e.row  = 0;
      e.due  = cyc + 1 + 2;
    end else begin
      r = 5;
      while (mdl[r][col] != 2'b00) r--;
      mdl[r][col] = 2'(ply);
      e.fail = 1'b0;
      e.row  = r;
      e.due  = cyc + 1 + 2 + (r + 1);
    end
    e.board = pack_model();
    sb.push_back(e);
    @(negedge clk);
    drop_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checki("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_board = 1'b1;
    sb.delete();
    clear_model();
    @(negedge clk);
    clear_board = 1'b0;
    check("clear_board_zero", board_state, 84'd0);
    checki("clear_busy", int'(busy), 0);
    checki("clear_fall_valid", int'(fall_valid), 0);
  endtask

  // Monitor: every pulse must match the oldest queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (drop_done || drop_fail)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0d fail=%0d expected none", drop_done, drop_fail);
      end else begin
        e = sb.pop_front();
        checki("pulse_is_fail", int'(drop_fail), int'(e.fail));
        checki("pulse_is_done", int'(drop_done), int'(!e.fail));
        checki("latency", cyc, e.due);
        check("board", board_state, e.board);
        checki("fall_valid_at_pulse", int'(fall_valid), 0);
        if (!e.fail) checki("placed_row", int'(placed_row), e.row);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [83:0] exp_b;
    int          s4;
    int          n;
    clear_model();
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;

    // Reset state.
    check("rst_board", board_state, 84'd0);
    checki("rst_busy", int'(busy), 0);
    checki("rst_fall_valid", int'(fall_valid), 0);
    checki("rst_fall_row", int'(fall_row), 0);
    checki("rst_placed_row", int'(placed_row), 0);
    checki("rst_pulses", int'(drop_done) + int'(drop_fail), 0);

    // Empty board, column 3, player 1: falls through rows 0..5.
    issue(3, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checki("fall_row_step", int'(fall_row), k);
      checki("fall_valid_step", int'(fall_valid), 1);
      checki("fall_col_step", int'(fall_col), 3);
      checki("busy_in_flight", int'(busy), 1);
    end
    wait_idle();
    checki("t1_cell_5_3", int'(board_state[77:76]), 1);

    // Column 0 pre-filled rows 5..2, player 2 lands at row 1.
    do_clear();
    issue(0, 1); wait_idle();
    issue(0, 2); wait_idle();
    issue(0, 1); wait_idle();
    issue(0, 2); wait_idle();
    issue(0, 2); wait_idle();
    checki("t2_cell_1_0", int'(board_state[15:14]), 2);

    // Full column, bad column, bad player.
    for (int k = 0; k < 6; k++) begin
      issue(6, 1 + (k % 2));
      wait_idle();
    end
    issue(6, 1); wait_idle();
    issue(7, 1); wait_idle();
    issue(4, 3); wait_idle();

    // Second request while busy is ignored.
    issue(2, 1);
    repeat (2) @(negedge clk);
    drop_req = 1'b1; column = 3'd5; player = 2'b10;
    @(negedge clk);
    drop_req = 1'b0;
    wait_idle();

    // Clear mid-fall on a non-empty board aborts silently.
    issue(4, 2);
    repeat (2) @(negedge clk);
    checki("midfall_valid", int'(fall_valid), 1);
    do_clear();
    repeat (12) @(negedge clk);

    // Clear and drop_req in the same cycle: clear wins.
    @(negedge clk);
    clear_board = 1'b1; drop_req = 1'b1; column = 3'd1; player = 2'b01;
    @(negedge clk);
    clear_board = 1'b0; drop_req = 1'b0;
    @(negedge clk);
    checki("clr_req_busy", int'(busy), 0);
    checki("clr_req_fall_valid", int'(fall_valid), 0);
    repeat (10) @(negedge clk);
    check("clr_req_board", board_state, 84'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      int pick;
      int ply;
      if ($urandom_range(0, 11) == 0) begin
        do_clear();
      end else begin
        pick = int'($urandom_range(0, 7));
        ply  = (pick < 3) ? 1 : (pick < 6) ? 2 : (pick == 6) ? 3 : 0;
        issue(int'($urandom_range(0, 7)), ply);
        if ($urandom_range(0, 1) == 1) begin
          drop_req = 1'b1;
          column   = 3'($urandom_range(0, 6));
          player   = 2'b01;
          @(negedge clk);
          drop_req = 1'b0;
        end
        wait_idle();
      end
    end

    // Asynchronous reset mid-fall on the FALL_DIV=4 instance.
    @(negedge clk);
    drop_req4 = 1'b1; column4 = 3'd4; player4 = 2'b01;
    @(negedge clk);
    drop_req4 = 1'b0;
    repeat (8) @(negedge clk);
    checki("u4_midfall_valid", int'(fall_valid4), 1);
    #2 rst4 = 1'b1;
    #1;
    check("u4_rst_board", board_state4, 84'd0);
    checki("u4_rst_busy", int'(busy4), 0);
    checki("u4_rst_fall_valid", int'(fall_valid4), 0);
    checki("u4_rst_fall_row", int'(fall_row4), 0);
    checki("u4_rst_pulses", int'(drop_done4) + int'(drop_fail4), 0);
    @(negedge clk);
    rst4 = 1'b0;
    @(negedge clk);
    drop_req4 = 1'b1; column4 = 3'd4; player4 = 2'b10;
    s4 = cyc + 1;
    @(negedge clk);
    drop_req4 = 1'b0;
    n = 0;
    while (!drop_done4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checki("u4_done_seen", int'(drop_done4), 1);
    checki("u4_latency", cyc - s4, 26);
    checki("u4_placed_row", int'(placed_row4), 5);
    exp_b = '0;
    exp_b[78 +: 2] = 2'b10;
    check("u4_board", board_state4, exp_b);

    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
